// File: rtl/stall_monitor.sv
`default_nettype none
// ============================================================================
// Module      : stall_monitor
// Description : Runtime monitor for RV32IMA pipeline stalls. Detects load-use
//               and load-to-branch hazards at ID/EX, checks each hazard stall
//               run against its expected length, bounds the length of any
//               stall run, and keeps saturating stall/hazard counters.
// Revision    : 1.0 - initial release
// ============================================================================
module stall_monitor #(
    parameter int MAX_STALL     = 2,
    parameter int BR_LOAD_STALL = 2,
    parameter int LD_USE_STALL  = 1,
    parameter int STRICT        = 1,
    parameter int CNT_W         = 16,
    parameter int REG_W         = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic [6:0]       opcode_id,
    input  logic [1:0]       branch_id,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             uses_rs2_id,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             clear,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] hazard_cnt,
    output logic [2:0]       err,
    output logic             err_any
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    localparam logic [6:0]       C_OP_LOAD   = 7'b0000011;
    localparam logic [1:0]       C_BR_COND   = 2'b01;
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_MAX_STALL = CNT_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] C_BR_STALL  = CNT_W'(BR_LOAD_STALL);
    localparam logic [CNT_W-1:0] C_LU_STALL  = CNT_W'(LD_USE_STALL);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ex_load;
    logic [CNT_W-1:0] r_run_len;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_hazard_cnt;
    logic [CNT_W-1:0] r_exp;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_exp_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_exp_len;
    logic [2:0]       r_err;
    logic [2:0]       w_err_evt;
    logic [2:0]       w_err_nxt;
    logic             r_err_any;
    logic             w_haz;
    logic             w_haz_inc;

    // A load in EX whose non-zero destination feeds an ID source is a hazard
    assign w_haz = r_ex_load && (rd_ex != '0) &&
                   ((rd_ex == rs1_id) || (uses_rs2_id && (rd_ex == rs2_id)));
    assign w_exp_len = (branch_id == C_BR_COND) ? C_BR_STALL : C_LU_STALL;

    // Error events are sticky; an event in the same cycle as clear survives
    assign w_err_nxt = clear ? w_err_evt : (r_err | w_err_evt);

    // FSM next-state, per-hazard measurement and error events
    always_comb begin
        w_state_nxt  = r_state;
        w_exp_nxt    = r_exp;
        w_cnt_nxt    = r_cnt;
        w_haz_inc    = 1'b0;
        w_err_evt    = 3'b000;
        w_err_evt[0] = stall && (r_run_len >= C_MAX_STALL);
        case (r_state)
            S_IDLE: begin
                if (w_haz) begin
                    w_haz_inc = 1'b1;
                    w_exp_nxt = w_exp_len;
                    w_cnt_nxt = stall ? C_CNT_ONE : '0;
                    if (stall) begin
                        w_state_nxt = S_MEASURE;
                    end else begin
                        w_err_evt[1] = 1'b1;
                    end
                end
            end
            S_MEASURE: begin
                // ID is held while stalling, so haz is not re-evaluated here
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (stall) begin
                    if (r_cnt != C_CNT_MAX) begin
                        w_cnt_nxt = r_cnt + C_CNT_ONE;
                    end
                end else begin
                    w_err_evt[1] = (r_cnt < r_exp);
                    w_err_evt[2] = (STRICT != 0) && (r_cnt > r_exp);
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state and measurement registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_exp   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // EX-stage load tracking and current stall-run length
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_load <= 1'b0;
            r_run_len <= '0;
        end else begin
            r_ex_load <= (opcode_id == C_OP_LOAD) && !stall && !flush;
            if (!stall) begin
                r_run_len <= '0;
            end else if (r_run_len != C_CNT_MAX) begin
                r_run_len <= r_run_len + C_CNT_ONE;
            end
        end
    end

    // Saturating performance counters and sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_hazard_cnt   <= '0;
            r_err          <= 3'b000;
            r_err_any      <= 1'b0;
        end else begin
            if (clear) begin
                r_stall_cycles <= '0;
                r_hazard_cnt   <= '0;
            end else begin
                if (stall && (r_stall_cycles != C_CNT_MAX)) begin
                    r_stall_cycles <= r_stall_cycles + C_CNT_ONE;
                end
                if (w_haz_inc && (r_hazard_cnt != C_CNT_MAX)) begin
                    r_hazard_cnt <= r_hazard_cnt + C_CNT_ONE;
                end
            end
            r_err     <= w_err_nxt;
            r_err_any <= |w_err_nxt;
        end
    end

    assign run_len      = r_run_len;
    assign stall_cycles = r_stall_cycles;
    assign hazard_cnt   = r_hazard_cnt;
    assign err          = r_err;
    assign err_any      = r_err_any;

endmodule
`default_nettype wire

// File: tb/tb_stall_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_stall_monitor
// Description : Self-checking bench for stall_monitor: directed vector table,
//               saturation / async-reset sequence, and randomized stimulus
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stall_monitor;

    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       stall = 1'b0, flush = 1'b0, uses_rs2_id = 1'b0, clear = 1'b0;
    logic [6:0] opcode_id = '0;
    logic [1:0] branch_id = '0;
    logic [4:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;

    logic [15:0] a_run, a_sc, a_hc, b_run, b_sc, b_hc;
    logic [3:0]  c_run, c_sc, c_hc;
    logic [2:0]  a_err, b_err, c_err;
    logic        a_any, b_any, c_any;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stall_monitor #(.STRICT(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .opcode_id(opcode_id),
        .branch_id(branch_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs2_id(uses_rs2_id),
        .rd_ex(rd_ex), .clear(clear), .run_len(a_run), .stall_cycles(a_sc),
        .hazard_cnt(a_hc), .err(a_err), .err_any(a_any));

    stall_monitor #(.STRICT(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .opcode_id(opcode_id),
        .branch_id(branch_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs2_id(uses_rs2_id),
        .rd_ex(rd_ex), .clear(clear), .run_len(b_run), .stall_cycles(b_sc),
        .hazard_cnt(b_hc), .err(b_err), .err_any(b_any));

    stall_monitor #(.STRICT(1), .CNT_W(4)) dut_c (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .opcode_id(opcode_id),
        .branch_id(branch_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs2_id(uses_rs2_id),
        .rd_ex(rd_ex), .clear(clear), .run_len(c_run), .stall_cycles(c_sc),
        .hazard_cnt(c_hc), .err(c_err), .err_any(c_any));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks "a hazard episode": the stall run that follows a detected
    // hazard, whose length is judged when the run ends.
    typedef struct {
        int       run;
        int       sc;
        int       hc;
        int       ep_len;
        int       ep_exp;
        bit       in_ep;
        bit       ex_load;
        bit [2:0] err;
    } m_t;

    function automatic m_t m_reset();
        m_t m;
        m.run = 0; m.sc = 0; m.hc = 0; m.ep_len = 0; m.ep_exp = 0;
        m.in_ep = 0; m.ex_load = 0; m.err = 3'b000;
        return m;
    endfunction

    function automatic int sat_inc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    function automatic m_t m_step(input m_t s, input int strict, input int cmax);
        m_t n = s;
        bit [2:0] ev = 3'b000;
        bit haz, newh;
        haz = s.ex_load && rd_ex != 0 &&
              (rd_ex == rs1_id || (uses_rs2_id && rd_ex == rs2_id));
        newh = 0;
        n.ex_load = (opcode_id == OP_LD) && !stall && !flush;
        n.run = stall ? sat_inc(s.run, cmax) : 0;
        if (stall && s.run >= 2) ev[0] = 1;
        if (!s.in_ep) begin
            if (haz) begin
                newh = 1;
                n.ep_exp = (branch_id == 2'b01) ? 2 : 1;
                n.ep_len = stall ? 1 : 0;
                if (stall) n.in_ep = 1;
                else ev[1] = 1;
            end
        end else if (flush) begin
            n.in_ep = 0;
        end else if (stall) begin
            n.ep_len = sat_inc(s.ep_len, cmax);
        end else begin
            if (s.ep_len < s.ep_exp) ev[1] = 1;
            if (strict != 0 && s.ep_len > s.ep_exp) ev[2] = 1;
            n.in_ep = 0;
        end
        n.sc  = clear ? 0 : (stall ? sat_inc(s.sc, cmax) : s.sc);
        n.hc  = clear ? 0 : (newh ? sat_inc(s.hc, cmax) : s.hc);
        n.err = clear ? ev : (s.err | ev);
        return n;
    endfunction

    m_t ma, mb, mc;

    task automatic check_models();
        chk("A.run_len", int'(a_run), ma.run);
        chk("A.stall_cycles", int'(a_sc), ma.sc);
        chk("A.hazard_cnt", int'(a_hc), ma.hc);
        chk("A.err", int'(a_err), int'(ma.err));
        chk("A.err_any", int'(a_any), int'(|ma.err));
        chk("B.run_len", int'(b_run), mb.run);
        chk("B.stall_cycles", int'(b_sc), mb.sc);
        chk("B.hazard_cnt", int'(b_hc), mb.hc);
        chk("B.err", int'(b_err), int'(mb.err));
        chk("B.err_any", int'(b_any), int'(|mb.err));
        chk("C.run_len", int'(c_run), mc.run);
        chk("C.stall_cycles", int'(c_sc), mc.sc);
        chk("C.hazard_cnt", int'(c_hc), mc.hc);
        chk("C.err", int'(c_err), int'(mc.err));
        chk("C.err_any", int'(c_any), int'(|mc.err));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst;
        bit         st, fl;
        logic [6:0] op;
        logic [1:0] br;
        logic [4:0] rs1, rs2;
        bit         u2;
        logic [4:0] rd;
        bit         clr;
        int         e_run, e_sc, e_hc;
        logic [2:0] e_err, e_err_ns;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input bit rst, input bit st, input bit fl,
                                input logic [6:0] op, input logic [1:0] br,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input bit u2, input logic [4:0] rd, input bit clr,
                                input int e_run, input int e_sc, input int e_hc,
                                input logic [2:0] e_err, input logic [2:0] e_err_ns);
        vec_t v;
        v.rst = rst; v.st = st; v.fl = fl; v.op = op; v.br = br;
        v.rs1 = rs1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.clr = clr;
        v.e_run = e_run; v.e_sc = e_sc; v.e_hc = e_hc;
        v.e_err = e_err; v.e_err_ns = e_err_ns;
        return v;
    endfunction

    task automatic drive(input bit st, input bit fl, input logic [6:0] op,
                         input logic [1:0] br, input logic [4:0] rs1,
                         input logic [4:0] rs2, input bit u2,
                         input logic [4:0] rd, input bit clr);
        stall = st; flush = fl; opcode_id = op; branch_id = br;
        rs1_id = rs1; rs2_id = rs2; uses_rs2_id = u2; rd_ex = rd; clear = clr;
    endtask

    // Called just after a rising edge; pulses reset well clear of the next edge
    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        ma = m_reset(); mb = m_reset(); mc = m_reset();
    endtask

    initial begin
        ma = m_reset(); mb = m_reset(); mc = m_reset();
        drive(0, 0, OP_ADDI, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_models();
        reset = 1'b1;

        // lw x5 / beq x5,x5 with 2-cycle stall: clean
        vt.push_back(mk(1, 0, 0, OP_LD,   0, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
        vt.push_back(mk(0, 1, 0, OP_BR,   1, 5, 5, 1, 5, 0,  1, 1, 1, 3'b000, 3'b000));
        vt.push_back(mk(0, 1, 0, OP_BR,   1, 5, 5, 1, 5, 0,  2, 2, 1, 3'b000, 3'b000));
        vt.push_back(mk(0, 0, 0, OP_ADDI, 0, 0, 0, 0, 5, 0,  0, 2, 1, 3'b000, 3'b000));
        // lw x5 / beq x5,x6 with 1-cycle stall: too short
        vt.push_back(mk(1, 0, 0, OP_LD,   0, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
        vt.push_back(mk(0, 1, 0, OP_BR,   1, 5, 6, 1, 5, 0,  1, 1, 1, 3'b000, 3'b000));
        vt.push_back(mk(0, 0, 0, OP_ADDI, 0, 0, 0, 0, 0, 0,  0, 1, 1, 3'b010, 3'b010));
        // lw x7 / add x8,x7,x1 with 3-cycle stall: too long + run overflow
        vt.push_back(mk(1, 0, 0, OP_LD,   0, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
        vt.push_back(mk(0, 1, 0, OP_ADD,  0, 7, 1, 1, 7, 0,  1, 1, 1, 3'b000, 3'b000));
        vt.push_back(mk(0, 1, 0, OP_ADD,  0, 7, 1, 1, 7, 0,  2, 2, 1, 3'b000, 3'b000));
        vt.push_back(mk(0, 1, 0, OP_ADD,  0, 7, 1, 1, 7, 0,  3, 3, 1, 3'b001, 3'b001));
        vt.push_back(mk(0, 0, 0, OP_ADDI, 0, 0, 0, 0, 0, 0,  0, 3, 1, 3'b101, 3'b001));
        // x0 destination is never a hazard; a flushed load is not tracked
        vt.push_back(mk(1, 0, 0, OP_LD,   0, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
        vt.push_back(mk(0, 0, 0, OP_ADD,  0, 0, 0, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000));
        vt.push_back(mk(0, 0, 1, OP_LD,   0, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
        vt.push_back(mk(0, 0, 0, OP_ADD,  0, 5, 0, 0, 5, 0,  0, 0, 0, 3'b000, 3'b000));
        // error then clear colliding with a new error: error wins
        vt.push_back(mk(1, 0, 0, OP_LD,   0, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
        vt.push_back(mk(0, 0, 0, OP_ADD,  0, 5, 0, 0, 5, 0,  0, 0, 1, 3'b010, 3'b010));
        vt.push_back(mk(0, 1, 0, OP_ADDI, 0, 0, 0, 0, 0, 0,  1, 1, 1, 3'b010, 3'b010));
        vt.push_back(mk(0, 0, 0, OP_LD,   0, 0, 0, 0, 0, 0,  0, 1, 1, 3'b010, 3'b010));
        vt.push_back(mk(0, 0, 0, OP_ADD,  0, 5, 0, 0, 5, 1,  0, 0, 0, 3'b010, 3'b010));
        vt.push_back(mk(0, 0, 0, OP_ADDI, 0, 0, 0, 0, 0, 1,  0, 0, 0, 3'b000, 3'b000));
        vt.push_back(mk(0, 1, 0, OP_ADDI, 0, 0, 0, 0, 0, 1,  1, 0, 0, 3'b000, 3'b000));
        vt.push_back(mk(0, 0, 0, OP_ADDI, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
        // flush during measurement abandons the check
        vt.push_back(mk(1, 0, 0, OP_LD,   0, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
        vt.push_back(mk(0, 1, 0, OP_ADD,  0, 5, 0, 0, 5, 0,  1, 1, 1, 3'b000, 3'b000));
        vt.push_back(mk(0, 1, 1, OP_ADD,  0, 5, 0, 0, 5, 0,  2, 2, 1, 3'b000, 3'b000));
        vt.push_back(mk(0, 0, 0, OP_ADDI, 0, 0, 0, 0, 0, 0,  0, 2, 1, 3'b000, 3'b000));
        // rs2 only counts when the instruction reads rs2
        vt.push_back(mk(0, 0, 0, OP_LD,   0, 0, 0, 0, 0, 0,  0, 2, 1, 3'b000, 3'b000));
        vt.push_back(mk(0, 0, 0, OP_ADD,  0, 1, 5, 0, 5, 0,  0, 2, 1, 3'b000, 3'b000));
        vt.push_back(mk(0, 0, 0, OP_LD,   0, 0, 0, 0, 0, 0,  0, 2, 1, 3'b000, 3'b000));
        vt.push_back(mk(0, 0, 0, OP_ADD,  0, 1, 5, 1, 5, 0,  0, 2, 2, 3'b010, 3'b010));

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset();
            drive(vt[i].st, vt[i].fl, vt[i].op, vt[i].br, vt[i].rs1, vt[i].rs2,
                  vt[i].u2, vt[i].rd, vt[i].clr);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.run_len", i), int'(a_run), vt[i].e_run);
            chk($sformatf("vec%0d.stall_cycles", i), int'(a_sc), vt[i].e_sc);
            chk($sformatf("vec%0d.hazard_cnt", i), int'(a_hc), vt[i].e_hc);
            chk($sformatf("vec%0d.err", i), int'(a_err), int'(vt[i].e_err));
            chk($sformatf("vec%0d.err_any", i), int'(a_any), int'(|vt[i].e_err));
            chk($sformatf("vec%0d.err_nonstrict", i), int'(b_err), int'(vt[i].e_err_ns));
        end

        // Long stall: 4-bit counters saturate; then async reset mid-run
        do_reset();
        drive(1, 0, OP_ADDI, 0, 0, 0, 0, 0, 0);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk("sat.C.run_len", int'(c_run), 15);
        chk("sat.C.stall_cycles", int'(c_sc), 15);
        chk("sat.A.run_len", int'(a_run), 20);
        chk("sat.A.stall_cycles", int'(a_sc), 20);
        chk("sat.A.err", int'(a_err), 1);
        #3;
        reset = 1'b0;
        #1;
        ma = m_reset(); mb = m_reset(); mc = m_reset();
        check_models();
        #1;
        reset = 1'b1;

        // Randomized stimulus against the model
        @(posedge clk);
        #1;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            logic [6:0] op;
            int sel;
            sel = $urandom_range(0, 9);
            op = (sel < 4) ? OP_LD : (sel < 6) ? OP_BR : (sel < 8) ? OP_ADD : OP_ADDI;
            drive($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 5, op,
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 99) < 3);
            ma = m_step(ma, 1, 65535);
            mb = m_step(mb, 0, 65535);
            mc = m_step(mc, 1, 15);
            @(posedge clk);
            #1;
            check_models();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stall_monitor.md
Name: stall_monitor

Overview:
- Synthesizable runtime monitor for RV32IMA pipeline stall behaviour; sits beside the hazard unit and observes the ID/EX stage signals.
- Detects load-use and load-to-branch hazards and measures each stall run's length against per-hazard expected lengths.
- Enforces a global maximum stall-run length and raises sticky error flags when a rule is broken.
- Keeps saturating performance counters readable by debug/CSR logic.

Parameters:
- MAX_STALL, 2, longest legal run of consecutive stall cycles.
- BR_LOAD_STALL, 2, required stall length when a branch in ID uses a load result in EX.
- LD_USE_STALL, 1, required stall length when a non-branch in ID uses a load result in EX.
- STRICT, 1, 1 = hazard runs must be exactly the expected length; 0 = expected length is a minimum.
- CNT_W, 16, width of the performance counters.
- REG_W, 5, register-address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline stall from the hazard unit (same-cycle view).
- flush  in  1  pipeline flush; kills the EX-stage load tracking.
- opcode_id  in  7  opcode of the instruction in ID.
- branch_id  in  2  branch type in ID; 2'b01 = conditional branch.
- rs1_id, rs2_id  in  REG_W  source registers in ID.
- uses_rs2_id  in  1  the ID instruction reads rs2.
- rd_ex  in  REG_W  destination register of the instruction in EX.
- clear  in  1  synchronous clear of counters and sticky errors.
- run_len  out  CNT_W  length of the current stall run (0 when not stalling).
- stall_cycles  out  CNT_W  total stall cycles, saturating.
- hazard_cnt  out  CNT_W  hazards detected, saturating.
- err  out  3  sticky errors: [0] run > MAX_STALL, [1] hazard stall too short, [2] hazard stall too long (STRICT only).
- err_any  out  1  OR of err.

Behaviour:
- Reset: all counters, run_len, err and ex_load_q are 0; FSM is in IDLE.
- ex_load_q tracking:
  - Each cycle, ex_load_q <= (opcode_id == 7'b0000011) && !stall && !flush.
  - When stall or flush is high, ex_load_q becomes 0, because a bubble enters EX.
- Hazard detection (combinational): haz = ex_load_q && rd_ex != 0 && (rd_ex == rs1_id || (uses_rs2_id && rd_ex == rs2_id)).
  - exp_len = BR_LOAD_STALL when branch_id == 2'b01; otherwise LD_USE_STALL.
- run_len:
  - If stall, run_len <= run_len + 1, saturating at all-ones; otherwise run_len <= 0.
  - err[0] is set in the cycle after the registered run_len reaches MAX_STALL while stall is still high, i.e. on the (MAX_STALL+1)-th consecutive stall cycle.
- FSM states: IDLE, MEASURE.
  - IDLE, haz = 1:
    - hazard_cnt increments.
    - exp_q <= exp_len; cnt_q <= stall ? 1 : 0.
    - If stall = 0, set err[1] immediately (a hazard with no stall is too short) and stay in IDLE.
    - Otherwise go to MEASURE.
  - MEASURE, stall = 1: cnt_q increments, saturating; haz is ignored because the same instruction is held in ID.
  - MEASURE, stall = 0 (run ended):
    - cnt_q < exp_q: set err[1].
    - cnt_q > exp_q and STRICT = 1: set err[2].
    - Return to IDLE; haz is evaluated in this same cycle only if the FSM was already IDLE, so a back-to-back hazard is picked up on the next cycle.
  - flush in MEASURE: return to IDLE with no check.
- stall_cycles increments every cycle stall = 1, saturating at 2^CNT_W - 1.
- clear:
  - Zeroes stall_cycles, hazard_cnt and err.
  - Does not affect run_len, FSM state or ex_load_q.
  - If an error event fires in the same cycle as clear, the error bit is set (error wins).
  - A counter increment in the same cycle as clear is dropped; the counter reads 0.
- err bits remain set until clear or reset.
- An asynchronous reset assertion mid-run returns everything to reset values immediately.
- All outputs are registered; err_any is registered OR of err.

Test Plan:
- lw x5 in EX, beq x5,x5 in ID, stall for 2 cycles then release -> hazard_cnt = 1, err = 3'b000, stall_cycles = 2, run_len peaks at 2.
- lw x5 in EX, beq x5,x6 in ID, stall for only 1 cycle -> err[1] = 1, err_any = 1 on the cycle after release.
- lw x7 in EX, add x8,x7,x1 in ID, stall for 3 cycles with STRICT = 1 -> err[2] = 1 and err[0] = 1 (3 > MAX_STALL). Repeat with STRICT = 0 -> only err[0] = 1.
- lw x0 in EX with a dependent x0 in ID, no stall -> hazard_cnt stays 0, err = 0. lw x5 followed by flush -> no hazard detected.
- Set err[1], then pulse clear in the same cycle as a new short-stall error -> err[1] remains 1, stall_cycles = 0.
- CNT_W = 4, hold stall for 20 cycles -> stall_cycles = 15 and run_len = 15 (both saturated). Assert reset mid-run -> all outputs 0 asynchronously.
